// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: opcodes, FSM states
// and the default datapath width.
package mips_md_pkg;

  localparam int LARGURA_PADRAO = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2
  } estado_t;

endpackage

// File: rtl/passo_mult_div.sv
// One combinational iteration of the multiply/divide unit: a shift-add step
// for multiplication or a restoring-division step for division.
module passo_mult_div #(
  parameter int LARGURA = 32
) (
  input  logic                   modo_div,
  input  logic                   bit_mult,
  input  logic [2*LARGURA-1:0]   acc_i,
  input  logic [2*LARGURA-1:0]   desl_i,
  output logic [2*LARGURA-1:0]   acc_o
);

  logic [LARGURA:0] topo;
  logic [LARGURA:0] dif;

  // Division keeps {remainder, dividend bits} in acc; the shifted remainder
  // needs one extra bit because it can reach twice the divisor.
  assign topo = acc_i[2*LARGURA-1:LARGURA-1];
  assign dif  = topo - {1'b0, desl_i[LARGURA-1:0]};

  always_comb begin
    acc_o = acc_i;
    if (modo_div) begin
      if (!dif[LARGURA]) begin
        acc_o = {dif[LARGURA-1:0], acc_i[LARGURA-2:0], 1'b1};
      end else begin
        acc_o = {topo[LARGURA-1:0], acc_i[LARGURA-2:0], 1'b0};
      end
    end else if (bit_mult) begin
      acc_o = acc_i + desl_i;
    end
  end

endmodule

// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One bit per cycle in CALC, sign correction and HI/LO commit in AJUSTE.
module unidade_mult_div
  import mips_md_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [2:0]         operacao,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  output logic [LARGURA-1:0] hi_out,
  output logic [LARGURA-1:0] lo_out,
  output logic               ocupado,
  output logic               pronto
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t estado_q, estado_d;
  logic [CW-1:0]          cont_q, cont_d;
  logic [2*LARGURA-1:0]   acc_q, acc_d;
  logic [2*LARGURA-1:0]   desl_q, desl_d;
  logic [LARGURA-1:0]     mult_q, mult_d;
  logic [LARGURA-1:0]     a_orig_q, a_orig_d;
  logic [LARGURA-1:0]     hi_q, hi_d;
  logic [LARGURA-1:0]     lo_q, lo_d;
  logic                   eh_div_q, eh_div_d;
  logic                   sinal_res_q, sinal_res_d;
  logic                   sinal_rem_q, sinal_rem_d;
  logic                   div_zero_q, div_zero_d;
  logic                   pronto_q, pronto_d;

  logic                   com_sinal;
  logic [LARGURA-1:0]     mag_a, mag_b;
  logic [2*LARGURA-1:0]   acc_passo;
  logic [2*LARGURA-1:0]   produto;
  logic [LARGURA-1:0]     quociente, resto;

  passo_mult_div #(.LARGURA(LARGURA)) u_passo (
    .modo_div (eh_div_q),
    .bit_mult (mult_q[0]),
    .acc_i    (acc_q),
    .desl_i   (desl_q),
    .acc_o    (acc_passo)
  );

  assign com_sinal = (operacao == OP_MULT) || (operacao == OP_DIV);
  assign mag_a     = (com_sinal && operando_a[LARGURA-1]) ? -operando_a : operando_a;
  assign mag_b     = (com_sinal && operando_b[LARGURA-1]) ? -operando_b : operando_b;

  assign produto   = sinal_res_q ? -acc_q : acc_q;
  assign quociente = sinal_res_q ? -acc_q[LARGURA-1:0] : acc_q[LARGURA-1:0];
  assign resto     = sinal_rem_q ? -acc_q[2*LARGURA-1:LARGURA] : acc_q[2*LARGURA-1:LARGURA];

  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    acc_d       = acc_q;
    desl_d      = desl_q;
    mult_d      = mult_q;
    a_orig_d    = a_orig_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    eh_div_d    = eh_div_q;
    sinal_res_d = sinal_res_q;
    sinal_rem_d = sinal_rem_q;
    div_zero_d  = div_zero_q;
    pronto_d    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          if (!operacao[2]) begin
            // Operands are reduced to magnitudes here so CALC is sign-agnostic.
            estado_d    = CALC;
            cont_d      = '0;
            eh_div_d    = operacao[1];
            sinal_res_d = com_sinal && (operando_a[LARGURA-1] ^ operando_b[LARGURA-1]);
            sinal_rem_d = com_sinal && operando_a[LARGURA-1];
            div_zero_d  = (operando_b == '0);
            a_orig_d    = operando_a;
            mult_d      = mag_b;
            if (operacao[1]) begin
              acc_d  = {{LARGURA{1'b0}}, mag_a};
              desl_d = {{LARGURA{1'b0}}, mag_b};
            end else begin
              acc_d  = '0;
              desl_d = {{LARGURA{1'b0}}, mag_a};
            end
          end else if (operacao == OP_MTHI) begin
            hi_d = operando_a;
          end else if (operacao == OP_MTLO) begin
            lo_d = operando_a;
          end
        end
      end

      CALC: begin
        acc_d  = acc_passo;
        mult_d = mult_q >> 1;
        if (!eh_div_q) begin
          desl_d = desl_q << 1;
        end
        if (cont_q == ULTIMO) begin
          estado_d = AJUSTE;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end

      AJUSTE: begin
        estado_d = OCIOSO;
        pronto_d = 1'b1;
        if (!eh_div_q) begin
          hi_d = produto[2*LARGURA-1:LARGURA];
          lo_d = produto[LARGURA-1:0];
        end else if (div_zero_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = resto;
          lo_d = quociente;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      acc_q       <= '0;
      desl_q      <= '0;
      mult_q      <= '0;
      a_orig_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      eh_div_q    <= 1'b0;
      sinal_res_q <= 1'b0;
      sinal_rem_q <= 1'b0;
      div_zero_q  <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cont_q      <= cont_d;
      acc_q       <= acc_d;
      desl_q      <= desl_d;
      mult_q      <= mult_d;
      a_orig_q    <= a_orig_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      eh_div_q    <= eh_div_d;
      sinal_res_q <= sinal_res_d;
      sinal_rem_q <= sinal_rem_d;
      div_zero_q  <= div_zero_d;
      pronto_q    <= pronto_d;
    end
  end

  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign ocupado = (estado_q != OCIOSO);
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: directed cases plus randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_unidade_mult_div;

  localparam int L = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          inicio;
  logic [2:0]    operacao;
  logic [L-1:0]  operando_a, operando_b;
  logic [L-1:0]  hi_out, lo_out;
  logic          ocupado, pronto;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] hi_m, lo_m;

  unidade_mult_div #(.LARGURA(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .inicio     (inicio),
    .operacao   (operacao),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .ocupado    (ocupado),
    .pronto     (pronto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics via plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [L-1:0] a, input logic [L-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = longint'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin
        if (b == 0) begin hi_m = a; lo_m = '1; end
        else begin q = sa / sb; r = sa % sb; hi_m = r[31:0]; lo_m = q[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin hi_m = a; lo_m = '1; end
        else begin p = ua / ub; hi_m = ua % ub; lo_m = p[31:0]; end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Issues one request at the current negedge and checks its outcome.
  // intrude: cycle at which an extra DIVU request is thrown in (0 = none).
  // settle: also check that pronto drops one cycle later.
  task automatic applyStimulus(input logic [2:0] op, input logic [L-1:0] a,
                               input logic [L-1:0] b, input int intrude, input bit settle);
    logic [L-1:0] hi_old, lo_old;
    int n;
    hi_old = hi_m;
    lo_old = lo_m;
    operacao = op; operando_a = a; operando_b = b; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    operando_a = $urandom; operando_b = $urandom;
    model(op, a, b);
    @(negedge clock);
    if (op[2]) begin
      chk("mt_hi", hi_out, hi_m);
      chk("mt_lo", lo_out, lo_m);
      chk("mt_ocupado", {31'd0, ocupado}, 32'd0);
      chk("mt_pronto", {31'd0, pronto}, 32'd0);
      return;
    end
    n = 0;
    while (ocupado === 1'b1 && n < 100) begin
      n++;
      if (n == intrude) begin
        inicio = 1'b1; operacao = 3'd3;
        operando_a = $urandom; operando_b = $urandom_range(1, 9);
      end
      if (n == intrude + 1) inicio = 1'b0;
      if (n == 33) begin
        chk("hold_hi", hi_out, hi_old);
        chk("hold_lo", lo_out, lo_old);
      end
      @(negedge clock);
    end
    inicio = 1'b0;
    chk("ocupado_cycles", n, 33);
    chk("pronto_pulse", {31'd0, pronto}, 32'd1);
    chk("res_hi", hi_out, hi_m);
    chk("res_lo", lo_out, lo_m);
    if (settle) begin
      @(negedge clock);
      chk("pronto_drop", {31'd0, pronto}, 32'd0);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_hi"}, hi_out, hi_m);
    chk({tag, "_lo"}, lo_out, lo_m);
    chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
    chk({tag, "_pronto"}, {31'd0, pronto}, 32'd0);
  endtask

  initial begin
    int n;
    bit saw_pronto;
    logic [2:0] rop;
    logic [L-1:0] ra, rb;

    reset = 1'b1; inicio = 1'b0; operacao = '0; operando_a = '0; operando_b = '0;
    hi_m = '0; lo_m = '0;
    #12;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 0, 1'b1);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1);
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b1);
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1);
    applyStimulus(3'd3, 32'h00001234, 32'd0, 0, 1'b1);
    applyStimulus(3'd2, 32'hFFFFF000, 32'd0, 0, 1'b1);

    applyStimulus(3'd4, 32'hAAAA0000, 32'd0, 0, 1'b0);
    applyStimulus(3'd5, 32'h5555AAAA, 32'd0, 0, 1'b0);
    applyStimulus(3'd1, 32'd3, 32'd5, 5, 1'b1);

    applyStimulus(3'd6, 32'h12345678, 32'd1, 0, 1'b0);
    applyStimulus(3'd7, 32'h87654321, 32'd1, 0, 1'b0);

    // Reset in the middle of a MULT: abort, clear HI/LO, no completion pulse.
    operacao = 3'd0; operando_a = 32'd1234; operando_b = 32'd99; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    hi_m = '0; lo_m = '0;
    checkOutput("midreset");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(3'd1, 32'd11, 32'd13, 0, 1'b1);

    reset = 1'b1;
    @(negedge clock);
    hi_m = '0; lo_m = '0;
    reset = 1'b0;
    saw_pronto = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pronto === 1'b1) saw_pronto = 1'b1;
      @(negedge clock);
    end
    chk("idle_no_pronto", {31'd0, saw_pronto}, 32'd0);

    // Randomized traffic, issued back-to-back in the cycle pronto is high.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      applyStimulus(rop, ra, rb, 0, 1'b0);
    end
    @(negedge clock);
    n = 0;
    chk("final_hi", hi_out, hi_m);
    chk("final_lo", lo_out, lo_m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
